// File: rtl/cpmg_pulse_train_gen.sv
// -----------------------------------------------------------------------------
// cpmg_pulse_train_gen
//
// Purpose:
//   Generates a repeating CPMG pulse train on the PLL clock. Each period starts
//   with one P1 pulse, followed by npulses refocusing P2 pulses. It also drives
//   a scope sync, a receiver inhibit, a one-cycle record trigger and an
//   attenuator word.
//   Host configuration is written into a pending set by cfg_load. The pending
//   set moves into the active (shadow) set only at the last cycle of a period,
//   or while idle. A host write therefore never disturbs a running sequence.
//
// Optional feature (compile-time macro OFFRES_EN):
//   This macro adds the input offres_delay and the output offres_on.
//   offres_on is high for c in [offres_delay, offres_delay+p1width), clipped at
//   the period end. offres_delay is shadowed like every other field.
//
// Ports:
//   clk_pll       PLL clock; all logic runs on its rising edge
//   resetn        asynchronous, active-low reset
//   enable        run request; sampled at period boundaries and in idle
//   cfg_load      one-cycle strobe: capture all cfg inputs into the pending set
//   period        cycles per repetition (0 keeps the block idle)
//   p1width       P1 width
//   p2width       P2 width
//   delay         tau: from the end of P1 to the start of the first P2
//   npulses       number of P2 pulses (0 = P1 only)
//   sync_up       cycle index where sync_on rises
//   att_down      cycle index where att switches from pp_probe to post_att
//   pp_probe      attenuator word for c < att_down
//   post_att      attenuator word for c >= att_down
//   pulse_on      switch drive (P1 or any P2)
//   sync_on       scope/digitiser sync
//   inhib         receiver inhibit, high until the last pulse ends
//   record_start  one-cycle record trigger at the last-pulse end
//   att           attenuator word (ATT_RST when idle)
//   pulse_idx     index of the current or last started pulse (0 = P1)
//   overrun       sticky flag: a sequence did not fit in its period
// -----------------------------------------------------------------------------
module cpmg_pulse_train_gen #(
    parameter int               CNT_W   = 32,
    parameter int               NP_W    = 8,
    parameter int               ATT_W   = 7,
    parameter logic [ATT_W-1:0] ATT_RST = 7'b1111111
) (
    input  logic              clk_pll,
    input  logic              resetn,
    input  logic              enable,
    input  logic              cfg_load,
    input  logic [CNT_W-1:0]  period,
    input  logic [CNT_W-1:0]  p1width,
    input  logic [CNT_W-1:0]  p2width,
    input  logic [CNT_W-1:0]  delay,
    input  logic [NP_W-1:0]   npulses,
    input  logic [CNT_W-1:0]  sync_up,
    input  logic [CNT_W-1:0]  att_down,
    input  logic [ATT_W-1:0]  pp_probe,
    input  logic [ATT_W-1:0]  post_att,
    output logic              pulse_on,
    output logic              sync_on,
    output logic              inhib,
    output logic              record_start,
    output logic [ATT_W-1:0]  att,
    output logic [NP_W-1:0]   pulse_idx,
    output logic              overrun
`ifdef OFFRES_EN
    ,
    input  logic [CNT_W-1:0]  offres_delay,
    output logic              offres_on
`endif
);

    // Time arithmetic is done at this width. The worst-case end time is
    // p1 + d + (N-1)*(2d+p2) + p2. That sum is below 2^(CNT_W+NP_W+2), so
    // the computation never wraps.
    localparam int EW = CNT_W + NP_W + 3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P1   = 3'd1,
        S_GAP  = 3'd2,
        S_P2   = 3'd3,
        S_TAIL = 3'd4
    } state_t;

    // One configuration set. s1, sp and e_end are derived from the raw fields
    // when the set is captured. This keeps the multiply off the per-cycle path.
    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] p1w;
        logic [CNT_W-1:0] p2w;
        logic [CNT_W-1:0] sync_up;
        logic [CNT_W-1:0] att_down;
`ifdef OFFRES_EN
        logic [CNT_W-1:0] offres_dly;
`endif
        logic [NP_W-1:0]  np;
        logic [ATT_W-1:0] pp_probe;
        logic [ATT_W-1:0] post_att;
        logic [EW-1:0]    s1;      // start of the first P2
        logic [EW-1:0]    sp;      // start-to-start spacing of P2 pulses
        logic [EW-1:0]    e_end;   // end of the last pulse
    } cfg_t;

    function automatic logic [EW-1:0] widen(input logic [CNT_W-1:0] v);
        return {{(EW-CNT_W){1'b0}}, v};
    endfunction

    function automatic logic [EW-1:0] widen_np(input logic [NP_W-1:0] v);
        return {{(EW-NP_W){1'b0}}, v};
    endfunction

    // ---------------------------------------------------------------------
    // Signals
    // ---------------------------------------------------------------------
    cfg_t             cfg_in;
    cfg_t             pend_q;
    cfg_t             sh_q;
    cfg_t             sh_d;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] c_q;
    logic [CNT_W-1:0] c_d;
    logic [NP_W-1:0]  k_q;
    logic [NP_W-1:0]  k_d;
    logic [EW-1:0]    nxt_q;
    logic [EW-1:0]    nxt_d;
    logic [EW-1:0]    last_q;
    logic [EW-1:0]    last_d;

    logic             at_end;
    logic             xfer;
    logic             run;
    logic             restart;
    logic [EW-1:0]    cw;
    logic [NP_W-1:0]  k_in;
    logic [EW-1:0]    nxt_in;
    logic [EW-1:0]    last_in;

    logic             pulse_on_q;
    logic             pulse_on_d;
    logic             sync_q;
    logic             sync_d;
    logic             inhib_q;
    logic             inhib_d;
    logic             rec_q;
    logic             rec_d;
    logic [ATT_W-1:0] att_q;
    logic [ATT_W-1:0] att_d;
    logic [NP_W-1:0]  idx_q;
    logic [NP_W-1:0]  idx_d;
    logic             ovr_q;
    logic             ovr_d;
`ifdef OFFRES_EN
    logic             offres_q;
    logic             offres_d;
`endif

    // ---------------------------------------------------------------------
    // Capture path: build a complete configuration set from the host inputs
    // ---------------------------------------------------------------------
    always_comb begin
        cfg_in          = '0;
        cfg_in.period   = period;
        cfg_in.p1w      = p1width;
        cfg_in.p2w      = p2width;
        cfg_in.sync_up  = sync_up;
        cfg_in.att_down = att_down;
`ifdef OFFRES_EN
        cfg_in.offres_dly = offres_delay;
`endif
        cfg_in.np       = npulses;
        cfg_in.pp_probe = pp_probe;
        cfg_in.post_att = post_att;
        cfg_in.s1       = widen(p1width) + widen(delay);
        cfg_in.sp       = (widen(delay) << 1) + widen(p2width);
        if (npulses == '0) begin
            cfg_in.e_end = widen(p1width);
        end else begin
            cfg_in.e_end = cfg_in.s1
                         + widen_np(npulses - NP_W'(1)) * cfg_in.sp
                         + widen(p2width);
        end
    end

    // ---------------------------------------------------------------------
    // State register process. It holds the counter, the pulse tracker, the
    // configuration sets and every registered output.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_pll or negedge resetn) begin
        if (!resetn) begin
            pend_q     <= '0;
            sh_q       <= '0;
            state_q    <= S_IDLE;
            c_q        <= '0;
            k_q        <= '0;
            nxt_q      <= '0;
            last_q     <= '0;
            pulse_on_q <= 1'b0;
            sync_q     <= 1'b0;
            inhib_q    <= 1'b0;
            rec_q      <= 1'b0;
            att_q      <= ATT_RST;
            idx_q      <= '0;
            ovr_q      <= 1'b0;
`ifdef OFFRES_EN
            offres_q   <= 1'b0;
`endif
        end else begin
            if (cfg_load) begin
                pend_q <= cfg_in;
            end
            sh_q       <= sh_d;
            state_q    <= state_d;
            c_q        <= c_d;
            k_q        <= k_d;
            nxt_q      <= nxt_d;
            last_q     <= last_d;
            pulse_on_q <= pulse_on_d;
            sync_q     <= sync_d;
            inhib_q    <= inhib_d;
            rec_q      <= rec_d;
            att_q      <= att_d;
            idx_q      <= idx_d;
            ovr_q      <= ovr_d;
`ifdef OFFRES_EN
            offres_q   <= offres_d;
`endif
        end
    end

    // ---------------------------------------------------------------------
    // Next-state process.
    // The outputs are registered, so this block works on the *next* cycle
    // index c_d and the next shadow set sh_d. The registers then show the
    // values for index c during the cycle whose index is c.
    // ---------------------------------------------------------------------
    always_comb begin
        at_end  = (c_q == sh_q.period - CNT_W'(1));
        xfer    = (state_q == S_IDLE) || at_end;
        sh_d    = xfer ? pend_q : sh_q;

        run     = 1'b0;
        restart = 1'b0;
        c_d     = '0;
        if (xfer) begin
            if (enable && (sh_d.period != '0)) begin
                run     = 1'b1;
                restart = 1'b1;
            end
        end else begin
            run = 1'b1;
            c_d = c_q + CNT_W'(1);
        end
        cw = widen(c_d);

        // Pulse tracker. nxt holds the start of the next P2 that has not yet
        // started. last holds the start of the most recent P2. Pulses never
        // overlap, so only the most recent one can be high. A zero spacing
        // means every P2 starts at the same instant, so the index jumps
        // straight to N.
        k_in    = restart ? '0       : k_q;
        nxt_in  = restart ? sh_d.s1  : nxt_q;
        last_in = restart ? '0       : last_q;
        k_d     = k_in;
        nxt_d   = nxt_in;
        last_d  = last_in;
        if (run && (k_in < sh_d.np) && (nxt_in <= cw)) begin
            last_d = nxt_in;
            nxt_d  = nxt_in + sh_d.sp;
            k_d    = (sh_d.sp == '0) ? sh_d.np : k_in + NP_W'(1);
        end
        if (!run) begin
            k_d    = '0;
            nxt_d  = '0;
            last_d = '0;
        end

        // A zero-width P2 never reaches S_P2. The sequence stays in GAP while
        // pulse_idx still advances.
        if (!run) begin
            state_d = S_IDLE;
        end else if (cw < widen(sh_d.p1w)) begin
            state_d = S_P1;
        end else if ((k_d != '0) && (cw < last_d + widen(sh_d.p2w))) begin
            state_d = S_P2;
        end else if (cw < sh_d.e_end) begin
            state_d = S_GAP;
        end else begin
            state_d = S_TAIL;
        end
    end

    // ---------------------------------------------------------------------
    // Output process: decode the next-cycle values of the registered outputs
    // ---------------------------------------------------------------------
    always_comb begin
        pulse_on_d = (state_d == S_P1) || (state_d == S_P2);
        inhib_d    = (state_d == S_P1) || (state_d == S_GAP) || (state_d == S_P2);
        // When e >= period the counter never reaches e, so no trigger fires.
        rec_d      = run && (cw == sh_d.e_end);
        sync_d     = run && (c_d >= sh_d.sync_up);
        if (!run) begin
            att_d = ATT_RST;
        end else if (c_d < sh_d.att_down) begin
            att_d = sh_d.pp_probe;
        end else begin
            att_d = sh_d.post_att;
        end
        idx_d      = run ? k_d : '0;
        // Overrun is judged once, when a period starts with its final settings.
        ovr_d      = ovr_q | (restart && (sh_d.e_end >= widen(sh_d.period)));
`ifdef OFFRES_EN
        offres_d   = run && (cw >= widen(sh_d.offres_dly))
                         && (cw <  widen(sh_d.offres_dly) + widen(sh_d.p1w));
`endif
    end

    assign pulse_on     = pulse_on_q;
    assign sync_on      = sync_q;
    assign inhib        = inhib_q;
    assign record_start = rec_q;
    assign att          = att_q;
    assign pulse_idx    = idx_q;
    assign overrun      = ovr_q;
`ifdef OFFRES_EN
    assign offres_on    = offres_q;
`endif

endmodule
